// File: rtl/zube_fifo.sv
`default_nettype none
// ============================================================================
// zube_fifo : CHANNELS x (TX/RX byte FIFO) mailbox, Z80 I/O bus <-> Wishbone.
// Optional: ZUBE_FIFO_IRQ_EN builds IRQ_EN registers and irq_out.  Rev 1.0
// ============================================================================
module zube_fifo #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h3000_0000,
  parameter logic [7:0]  Z80_PORT_BASE = 8'h40,
  parameter int          CHANNELS      = 2,
  parameter int          DEPTH_LOG2    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                z80_write_strobe_b,
  input  logic                z80_read_strobe_b,
  input  logic [7:0]          z80_address_bus,
  input  logic [7:0]          z80_data_bus_in,
  output logic [7:0]          z80_data_bus_out,
  output logic                z80_bus_dir,
  input  logic                wb_cyc_in,
  input  logic                wb_stb_in,
  input  logic                wb_we_in,
  input  logic [31:0]         wb_addr_in,
  input  logic [31:0]         wb_data_in,
  output logic                wb_ack_out,
  output logic [31:0]         wb_data_out,
  output logic [CHANNELS-1:0] irq_out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [1:0]                           wr_sync_q, wr_sync_d, rd_sync_q, rd_sync_d;
  logic                                 wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
  logic [CHANNELS-1:0][PW-1:0]          rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CHANNELS-1:0][PW-1:0]          tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CHANNELS-1:0][DEPTH-1:0][7:0]  rx_mem_q, rx_mem_d, tx_mem_q, tx_mem_d;
  logic [CHANNELS-1:0]                  rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic [CHANNELS-1:0]                  tx_pend_q, tx_pend_d;
  logic [CHANNELS-1:0][1:0]             irq_en_q, irq_en_d;
  logic                                 wb_ack_q, wb_ack_d;
  logic [31:0]                          wb_data_q, wb_data_d;
  logic [7:0]                           z_out_q, z_out_d;
  logic                                 z_dir_q, z_dir_d;

  logic [CHANNELS-1:0][PW-1:0]          rx_cnt, tx_cnt;
  logic [CHANNELS-1:0]                  rx_full, rx_empty, tx_full, tx_empty;
  logic [CHANNELS-1:0][7:0]             rx_head, tx_head, z_status;
  logic [CHANNELS-1:0]                  z_data_hit, z_stat_hit, wb_ch_hit;
  logic [CHANNELS-1:0]                  rx_push, rx_pop, tx_push, tx_pop;
  logic [31:0]                          wb_off;
  logic                                 wb_req, wb_hit, z_wr_fall, z_rd_fall, z_rd_rise;
  logic                                 unused_bits;

  assign wb_off      = wb_addr_in - BASE_ADDRESS;
  assign wb_hit      = wb_off < 32'(16 * CHANNELS);
  assign wb_req      = wb_cyc_in & wb_stb_in & ~wb_ack_q;
  assign z_wr_fall   = wr_prev_q & ~wr_sync_q[1];
  assign z_rd_fall   = rd_prev_q & ~rd_sync_q[1];
  assign z_rd_rise   = ~rd_prev_q & rd_sync_q[1];
  assign unused_bits = &{1'b0, wb_data_in[31:18], wb_data_in[15:8]};

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      assign rx_cnt[c]     = rx_wp_q[c] - rx_rp_q[c];
      assign tx_cnt[c]     = tx_wp_q[c] - tx_rp_q[c];
      assign rx_empty[c]   = rx_wp_q[c] == rx_rp_q[c];
      assign tx_empty[c]   = tx_wp_q[c] == tx_rp_q[c];
      assign rx_full[c]    = (rx_wp_q[c][PW-1] != rx_rp_q[c][PW-1]) &&
                             (rx_wp_q[c][PW-2:0] == rx_rp_q[c][PW-2:0]);
      assign tx_full[c]    = (tx_wp_q[c][PW-1] != tx_rp_q[c][PW-1]) &&
                             (tx_wp_q[c][PW-2:0] == tx_rp_q[c][PW-2:0]);
      assign rx_head[c]    = rx_mem_q[c][rx_rp_q[c][PW-2:0]];
      assign tx_head[c]    = tx_mem_q[c][tx_rp_q[c][PW-2:0]];
      assign z_data_hit[c] = z80_address_bus == (Z80_PORT_BASE + 8'(2 * c));
      assign z_stat_hit[c] = z80_address_bus == (Z80_PORT_BASE + 8'(2 * c + 1));
      assign z_status[c]   = {4'b0, tx_ovf_q[c], rx_ovf_q[c], ~rx_full[c], ~tx_empty[c]};
      assign wb_ch_hit[c]  = wb_hit && (wb_off[31:4] == 28'(c));
      assign rx_push[c]    = z_wr_fall & z_data_hit[c];
      assign rx_pop[c]     = wb_req & wb_ch_hit[c] & ~wb_we_in & (wb_off[3:0] == 4'h0) & ~rx_empty[c];
      assign tx_push[c]    = wb_req & wb_ch_hit[c] & wb_we_in & (wb_off[3:0] == 4'h0);
      // pend is only ever set when TX was non-empty and nothing else pops TX
      assign tx_pop[c]     = z_rd_rise & tx_pend_q[c];
`ifdef ZUBE_FIFO_IRQ_EN
      assign irq_out[c]    = (irq_en_q[c][0] & ~rx_empty[c]) | (irq_en_q[c][1] & tx_empty[c]);
`endif
    end
  endgenerate

`ifndef ZUBE_FIFO_IRQ_EN
  assign irq_out = '0;
`endif

  always_comb begin
    wr_sync_d = {wr_sync_q[0], z80_write_strobe_b};
    rd_sync_d = {rd_sync_q[0], z80_read_strobe_b};
    wr_prev_d = wr_sync_q[1];
    rd_prev_d = rd_sync_q[1];
    rx_wp_d   = rx_wp_q;
    rx_rp_d   = rx_rp_q;
    tx_wp_d   = tx_wp_q;
    tx_rp_d   = tx_rp_q;
    rx_mem_d  = rx_mem_q;
    tx_mem_d  = tx_mem_q;
    rx_ovf_d  = rx_ovf_q;
    tx_ovf_d  = tx_ovf_q;
    tx_pend_d = tx_pend_q;
    irq_en_d  = irq_en_q;
    wb_ack_d  = wb_req;
    wb_data_d = '0;
    z_out_d   = z_out_q;
    z_dir_d   = z_dir_q;
    if (z_rd_rise) begin
      z_dir_d = 1'b0;
      z_out_d = 8'h00;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (z_rd_rise) tx_pend_d[c] = 1'b0;
      if (z_rd_fall) begin
        tx_pend_d[c] = z_data_hit[c] & ~tx_empty[c];
        if (z_data_hit[c]) begin
          z_dir_d = 1'b1;
          z_out_d = tx_empty[c] ? 8'h00 : tx_head[c];
        end
        if (z_stat_hit[c]) begin
          z_dir_d = 1'b1;
          z_out_d = z_status[c];
        end
      end
      if (wb_req && wb_ch_hit[c]) begin
        if (!wb_we_in) begin
          case (wb_off[3:0])
            4'h0:    wb_data_d = {24'b0, rx_empty[c] ? 8'h00 : rx_head[c]};
            4'h4:    wb_data_d = {14'b0, tx_ovf_q[c], rx_ovf_q[c], 8'(tx_cnt[c]), 8'(rx_cnt[c])};
            4'h8:    wb_data_d = {30'b0, irq_en_q[c]};
            default: wb_data_d = '0;
          endcase
        end else if (wb_off[3:0] == 4'h4) begin
          if (wb_data_in[16]) rx_ovf_d[c] = 1'b0;
          if (wb_data_in[17]) tx_ovf_d[c] = 1'b0;
        end
`ifdef ZUBE_FIFO_IRQ_EN
        else if (wb_off[3:0] == 4'h8) begin
          irq_en_d[c] = wb_data_in[1:0];
        end
`endif
      end
      // A push into a full FIFO is accepted when a pop frees the slot in the same cycle
      if (rx_pop[c]) rx_rp_d[c] = rx_rp_q[c] + PW'(1);
      if (rx_push[c]) begin
        if (!rx_full[c] || rx_pop[c]) begin
          rx_mem_d[c][rx_wp_q[c][PW-2:0]] = z80_data_bus_in;
          rx_wp_d[c] = rx_wp_q[c] + PW'(1);
        end else begin
          rx_ovf_d[c] = 1'b1;
        end
      end
      if (tx_pop[c]) tx_rp_d[c] = tx_rp_q[c] + PW'(1);
      if (tx_push[c]) begin
        if (!tx_full[c] || tx_pop[c]) begin
          tx_mem_d[c][tx_wp_q[c][PW-2:0]] = wb_data_in[7:0];
          tx_wp_d[c] = tx_wp_q[c] + PW'(1);
        end else begin
          tx_ovf_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sync_q <= 2'b11;
      rd_sync_q <= 2'b11;
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_mem_q  <= '0;
      tx_mem_q  <= '0;
      rx_ovf_q  <= '0;
      tx_ovf_q  <= '0;
      tx_pend_q <= '0;
      irq_en_q  <= '0;
      wb_ack_q  <= 1'b0;
      wb_data_q <= '0;
      z_out_q   <= '0;
      z_dir_q   <= 1'b0;
    end else begin
      wr_sync_q <= wr_sync_d;
      rd_sync_q <= rd_sync_d;
      wr_prev_q <= wr_prev_d;
      rd_prev_q <= rd_prev_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_mem_q  <= rx_mem_d;
      tx_mem_q  <= tx_mem_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_ovf_q  <= tx_ovf_d;
      tx_pend_q <= tx_pend_d;
      irq_en_q  <= irq_en_d;
      wb_ack_q  <= wb_ack_d;
      wb_data_q <= wb_data_d;
      z_out_q   <= z_out_d;
      z_dir_q   <= z_dir_d;
    end
  end

  assign wb_ack_out       = wb_ack_q;
  assign wb_data_out      = wb_data_q;
  assign z80_data_bus_out = z_out_q;
  assign z80_bus_dir      = z_dir_q;

endmodule
`default_nettype wire
